// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 2-flop synchronized input) feeding a first-word-fall-through
// byte FIFO with a stored count, sticky overrun / framing flags and a synchronous flush.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_ADDR_W  = 9
) (
  input  logic                   WBs_CLK_i,
  input  logic                   WBs_RST_n_i,
  input  logic                   uart_rx_i,
  input  logic                   rx_en_i,
  input  logic                   fifo_rst_i,
  input  logic                   pop_i,
  input  logic                   ovrrun_clr_i,
  output logic [7:0]             rx_data_o,
  output logic [FIFO_ADDR_W:0]   rx_fifo_cnt_o,
  output logic                   rx_empty_o,
  output logic                   rx_full_o,
  output logic                   fifo_ovrrun_o,
  output logic                   frame_err_o
);

  localparam int                     DEPTH     = 1 << FIFO_ADDR_W;
  localparam logic [15:0]            BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]            HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_ADDR_W-1:0] PTR_ONE   = FIFO_ADDR_W'(1);
  localparam logic [FIFO_ADDR_W:0]   CNT_ONE   = (FIFO_ADDR_W + 1)'(1);
  localparam logic [FIFO_ADDR_W:0]   CNT_FULL  = (FIFO_ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  logic                   rx_meta_r;
  logic                   rx_sync_r;
  logic                   rx_prev_r;

  rx_state_t              state_r;
  rx_state_t              state_nxt_s;
  logic [15:0]            bit_cnt_r;
  logic [15:0]            bit_cnt_nxt_s;
  logic [2:0]             bit_idx_r;
  logic [2:0]             bit_idx_nxt_s;
  logic [7:0]             shift_r;
  logic [7:0]             shift_nxt_s;
  logic                   push_s;
  logic                   frame_set_s;

  logic [7:0]             mem_r [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_r;
  logic [FIFO_ADDR_W-1:0] rd_ptr_r;
  logic [FIFO_ADDR_W:0]   cnt_r;
  logic [FIFO_ADDR_W:0]   cnt_nxt_s;
  logic [7:0]             data_r;
  logic [7:0]             head_nxt_s;
  logic                   empty_r;
  logic                   full_r;
  logic                   ovrrun_r;
  logic                   frame_err_r;
  logic                   do_push_s;
  logic                   do_pop_s;
  logic                   drop_s;

  // Input synchronizer plus one extra stage for falling-edge detection; idle level is 1.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Receiver next-state logic; rx_en_i only gates leaving IDLE, never aborts a frame.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    push_s        = 1'b0;
    frame_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bit_cnt_nxt_s = 16'd0;
        if (rx_prev_r && !rx_sync_r && rx_en_i) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_cnt_r == HALF_LAST) begin
          bit_cnt_nxt_s = 16'd0;
          bit_idx_nxt_s = 3'd0;
          if (!rx_sync_r) begin
            state_nxt_s = ST_DATA;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_nxt_s = 16'd0;
          shift_nxt_s   = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_nxt_s = 16'd0;
          state_nxt_s   = ST_IDLE;
          if (rx_sync_r) begin
            push_s = 1'b1;
          end else begin
            frame_set_s = 1'b1;
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  assign do_push_s = push_s && (!full_r || pop_i);
  assign do_pop_s  = pop_i && !empty_r;
  assign drop_s    = push_s && full_r && !pop_i;

  // Next count and next head byte; the head register keeps rx_data_o registered and zero when empty.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    head_nxt_s = data_r;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
    if (cnt_nxt_s == '0) begin
      head_nxt_s = 8'h00;
    end else if (do_pop_s) begin
      if (cnt_r == CNT_ONE) begin
        head_nxt_s = shift_r;
      end else begin
        head_nxt_s = mem_r[rd_ptr_r + PTR_ONE];
      end
    end else if (cnt_r == '0) begin
      head_nxt_s = shift_r;
    end else begin
      head_nxt_s = data_r;
    end
  end

  // Storage array, no reset needed: only entries below the count are ever read.
  always_ff @(posedge WBs_CLK_i) begin
    if (do_push_s && !fifo_rst_i) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // FIFO pointers, count, head and status; the flush overrides any same-cycle push or pop.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      data_r   <= 8'h00;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else if (fifo_rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      data_r   <= 8'h00;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r   <= cnt_nxt_s;
      data_r  <= head_nxt_s;
      empty_r <= (cnt_nxt_s == '0);
      full_r  <= (cnt_nxt_s == CNT_FULL);
    end
  end

  // Sticky error flags: a set event beats a same-cycle clear.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      ovrrun_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else if (fifo_rst_i) begin
      ovrrun_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      ovrrun_r    <= drop_s || (ovrrun_r && !ovrrun_clr_i);
      frame_err_r <= frame_set_s || (frame_err_r && !ovrrun_clr_i);
    end
  end

  assign rx_data_o     = data_r;
  assign rx_fifo_cnt_o = cnt_r;
  assign rx_empty_o    = empty_r;
  assign rx_full_o     = full_r;
  assign fifo_ovrrun_o = ovrrun_r;
  assign frame_err_o   = frame_err_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven bit by bit, expected bytes are
// queued at send time and a monitor compares the head byte whenever a pop is accepted.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic          rx_en;
  logic          fifo_rst;
  logic          pop;
  logic          ovrrun_clr;
  logic [7:0]    rx_data;
  logic [AW:0]   rx_cnt;
  logic          rx_empty;
  logic          rx_full;
  logic          ovrrun;
  logic          frame_err;

  int            checks   = 0;
  int            failures = 0;
  logic [7:0]    exp_q [$];
  logic [7:0]    mon_exp;
  logic [AW:0]   cnt_154;
  logic [AW:0]   cnt_155;
  logic [7:0]    data_155;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(AW)) dut (
    .WBs_CLK_i     (clk),
    .WBs_RST_n_i   (rst_n),
    .uart_rx_i     (uart_rx),
    .rx_en_i       (rx_en),
    .fifo_rst_i    (fifo_rst),
    .pop_i         (pop),
    .ovrrun_clr_i  (ovrrun_clr),
    .rx_data_o     (rx_data),
    .rx_fifo_cnt_o (rx_cnt),
    .rx_empty_o    (rx_empty),
    .rx_full_o     (rx_full),
    .fifo_ovrrun_o (ovrrun),
    .frame_err_o   (frame_err)
  );

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && pop && !rx_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_data: got %h, no byte expected", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          failures++;
          $display("FAIL pop_data: got %h want %h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic clr_pulse();
    ovrrun_clr = 1'b1;
    tick();
    ovrrun_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  rx_data,   8'h00);
    check({tag, "_cnt"},   rx_cnt,    3'd0);
    check({tag, "_empty"}, rx_empty,  1'b1);
    check({tag, "_full"},  rx_full,   1'b0);
    check({tag, "_ovr"},   ovrrun,    1'b0);
    check({tag, "_ferr"},  frame_err, 1'b0);
  endtask

  // mode: 0 plain, 1 pop on the push cycle, 2 flush on the push cycle, 3 reset at data bit 4
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      uart_rx  = bits[c / CPB];
      pop      = (mode == 1) && (c == 154);
      fifo_rst = (mode == 2) && (c == 154);
      if (mode == 3 && c == 88) begin
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        return;
      end
      if (c == 154) cnt_154 = rx_cnt;
      if (c == 155) begin
        cnt_155  = rx_cnt;
        data_155 = rx_data;
      end
      tick();
    end
    pop      = 1'b0;
    fifo_rst = 1'b0;
    uart_rx  = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0; uart_rx = 1'b1; rx_en = 1'b1;
    fifo_rst = 1'b0; pop = 1'b0; ovrrun_clr = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    // single good frame, latency of one cycle after the stop sample
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0);
    check("a5_cnt_before", cnt_154, 3'd0);
    check("a5_cnt_after",  cnt_155, 3'd1);
    check("a5_data_after", data_155, 8'hA5);
    check("a5_empty", rx_empty, 1'b0);
    check("a5_data",  rx_data,  8'hA5);
    do_pop();
    check("a5_pop_cnt",  rx_cnt,  3'd0);
    check("a5_pop_data", rx_data, 8'h00);
    do_pop();
    check("pop_empty_cnt",   rx_cnt,   3'd0);
    check("pop_empty_empty", rx_empty, 1'b1);

    // short glitch is not a start bit
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (40) tick();
    check("glitch_cnt",  rx_cnt,    3'd0);
    check("glitch_ferr", frame_err, 1'b0);
    check("glitch_ovr",  ovrrun,    1'b0);

    // framing error, then clear
    send_frame(8'h3C, 1'b0, 0);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_cnt", rx_cnt,    3'd0);
    clr_pulse();
    check("ferr_clr", frame_err, 1'b0);

    // overflow of the 4-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
    end
    check("ovf_cnt",  rx_cnt,  3'd4);
    check("ovf_full", rx_full, 1'b1);
    check("ovf_flag", ovrrun,  1'b1);
    check("ovf_head", rx_data, 8'h01);
    repeat (4) do_pop();
    check("ovf_drain_empty", rx_empty, 1'b1);
    clr_pulse();
    check("ovf_clr", ovrrun, 1'b0);

    // push with same-cycle pop while full
    for (int i = 6; i <= 9; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
    end
    check("refill_full", rx_full, 1'b1);
    exp_q.push_back(8'h0A);
    send_frame(8'h0A, 1'b1, 1);
    check("pushpop_cnt",  rx_cnt,  3'd4);
    check("pushpop_ovr",  ovrrun,  1'b0);
    check("pushpop_head", rx_data, 8'h07);
    repeat (4) do_pop();
    check("pushpop_drain", rx_cnt, 3'd0);

    // flush coincident with a push
    send_frame(8'h77, 1'b0, 0);
    check("flush_ferr_pre", frame_err, 1'b1);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    check("flush_cnt_pre", rx_cnt, 3'd3);
    send_frame(8'h44, 1'b1, 2);
    check_reset_outputs("flush");

    // reset in the middle of a frame
    send_frame(8'h99, 1'b1, 0);
    send_frame(8'h5A, 1'b0, 0);
    check("rst_pre_cnt",  rx_cnt,    3'd1);
    check("rst_pre_ferr", frame_err, 1'b1);
    send_frame(8'h55, 1'b1, 3);
    repeat (3) tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (3) tick();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0);
    check("post_rst_cnt",  rx_cnt,  3'd1);
    check("post_rst_data", rx_data, 8'h81);
    do_pop();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
